bbox_test_arbiter: RTL and testbench

//  Shares one pipelined ray/AABB intersection unit among NUM_REQ traversal requesters.
//  - Round-robin grants one ray/box test per cycle into the unit.
//  - Carries requester id and tag alongside the unit's fixed latency.
//  - Returns each hit/distance on a single valid/ready response channel.
//  - Owns the unit's stall input: response backpressure freezes the whole pipeline.
//  - Sits between the BVH traversal engines and the intersection unit, which shares clk/rst_n.

---
 rtl/bbox_test_arbiter.sv | 133 +++++++++++++
 tb/tb_bbox_test_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_test_arbiter.sv
// Round-robin front end for a shared, fixed-latency ray/AABB intersection pipeline.
// Tracks requester id/tag alongside the unit and drives its stall from response backpressure.
module bbox_test_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DP_LATENCY = 4,
  parameter int unsigned TAG_W      = 16,
  parameter int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned COORD_W    = 32,
  parameter int unsigned INV_W      = 36,
  parameter int unsigned DIST_W     = 49
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ-1:0][3*COORD_W-1:0]       req_ray_orig,
  input  logic [NUM_REQ-1:0][3*INV_W-1:0]         req_inv_dir,
  input  logic [NUM_REQ-1:0][2:0]                 req_div_by_zero,
  input  logic [NUM_REQ-1:0][6*COORD_W-1:0]       req_box,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]           req_tag,
  output logic                                    dp_stall,
  output logic [3*COORD_W-1:0]                    dp_ray_orig,
  output logic [3*INV_W-1:0]                      dp_inv_ray_dir,
  output logic [2:0]                              dp_div_by_zero,
  output logic [6*COORD_W-1:0]                    dp_box,
  input  logic                                    dp_hit,
  input  logic signed [DIST_W-1:0]                dp_dist,
  output logic                                    rsp_valid,
  input  logic                                    rsp_ready,
  output logic [ID_W-1:0]                         rsp_id,
  output logic [TAG_W-1:0]                        rsp_tag,
  output logic                                    rsp_hit,
  output logic signed [DIST_W-1:0]                rsp_dist,
  output logic                                    busy,
  output logic [31:0]                             stall_cycles
);

  logic [DP_LATENCY-1:0]            vld_q;
  logic [DP_LATENCY-1:0][ID_W-1:0]  id_q;
  logic [DP_LATENCY-1:0][TAG_W-1:0] tag_q;
  logic [ID_W-1:0]                  ptr_q, ptr_d;
  logic [31:0]                      stall_cnt_q, stall_cnt_d;

  logic                             grant_found;
  logic                             grant_en;
  logic [ID_W-1:0]                  grant_idx;

  // The unit stalls exactly when the oldest result cannot leave.
  assign rsp_valid = vld_q[DP_LATENCY-1];
  assign rsp_id    = id_q[DP_LATENCY-1];
  assign rsp_tag   = tag_q[DP_LATENCY-1];
  assign rsp_hit   = dp_hit;
  assign rsp_dist  = dp_dist;
  assign dp_stall  = rsp_valid & ~rsp_ready;
  assign busy      = |vld_q;
  assign stall_cycles = stall_cnt_q;

  always_comb begin
    int unsigned cand;
    logic [ID_W-1:0] cidx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cidx        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = ID_W'(cand);
      if (!grant_found && req_valid[cidx]) begin
        grant_found = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

  // Gating with rst_n keeps req_ready low for the whole reset assertion.
  assign grant_en = grant_found & ~dp_stall & rst_n;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_en && (grant_idx == ID_W'(i));
    end
  end

  always_comb begin
    dp_ray_orig    = '0;
    dp_inv_ray_dir = '0;
    dp_div_by_zero = '0;
    dp_box         = '0;
    if (grant_en) begin
      dp_ray_orig    = req_ray_orig[grant_idx];
      dp_inv_ray_dir = req_inv_dir[grant_idx];
      dp_div_by_zero = req_div_by_zero[grant_idx];
      dp_box         = req_box[grant_idx];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
    stall_cnt_d = stall_cnt_q;
    if (dp_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      id_q        <= '0;
      tag_q       <= '0;
      ptr_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      stall_cnt_q <= stall_cnt_d;
      if (!dp_stall) begin
        vld_q[0] <= grant_en;
        id_q[0]  <= grant_idx;
        tag_q[0] <= req_tag[grant_idx];
        for (int unsigned i = 1; i < DP_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          id_q[i]  <= id_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_bbox_test_arbiter.sv
// Directed vector bench for bbox_test_arbiter: per-cycle table plus a reset-in-flight sequence.
module tb_bbox_test_arbiter;

  localparam int unsigned NREQ = 4;
  localparam logic signed [48:0] INFINITY_49 = 49'h0_FFFF_FFFF_FFFF;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic [NREQ-1:0]              req_valid = '0;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0][95:0]        req_ray_orig;
  logic [NREQ-1:0][107:0]       req_inv_dir;
  logic [NREQ-1:0][2:0]         req_div_by_zero;
  logic [NREQ-1:0][191:0]       req_box;
  logic [NREQ-1:0][15:0]        req_tag;
  logic                         dp_stall;
  logic [95:0]                  dp_ray_orig;
  logic [107:0]                 dp_inv_ray_dir;
  logic [2:0]                   dp_div_by_zero;
  logic [191:0]                 dp_box;
  logic                         dp_hit = 1'b0;
  logic signed [48:0]           dp_dist = '0;
  logic                         rsp_valid;
  logic                         rsp_ready = 1'b1;
  logic [1:0]                   rsp_id;
  logic [15:0]                  rsp_tag;
  logic                         rsp_hit;
  logic signed [48:0]           rsp_dist;
  logic                         busy;
  logic [31:0]                  stall_cycles;

  bbox_test_arbiter #(.NUM_REQ(NREQ), .DP_LATENCY(4), .TAG_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ray_orig(req_ray_orig), .req_inv_dir(req_inv_dir),
    .req_div_by_zero(req_div_by_zero), .req_box(req_box), .req_tag(req_tag),
    .dp_stall(dp_stall), .dp_ray_orig(dp_ray_orig), .dp_inv_ray_dir(dp_inv_ray_dir),
    .dp_div_by_zero(dp_div_by_zero), .dp_box(dp_box),
    .dp_hit(dp_hit), .dp_dist(dp_dist),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_hit(rsp_hit), .rsp_dist(rsp_dist), .busy(busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rv;    // req_valid
    logic       rr;    // rsp_ready
    logic [3:0] rdy;   // expected req_ready
    logic       vld;   // expected rsp_valid
    logic [1:0] id;    // expected rsp_id when vld
    logic       busy;  // expected busy
    logic       inf;   // unit reports a miss at infinity this cycle
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] tag;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] rv, input logic rr, input logic [3:0] rdy,
                     input logic vld, input logic [1:0] id, input logic bsy, input logic inf);
    vec_t v;
    v.rv = rv; v.rr = rr; v.rdy = rdy; v.vld = vld; v.id = id; v.busy = bsy; v.inf = inf;
    tbl.push_back(v);
  endtask

  // One clock cycle: drive at negedge, check 1ns later, bump accepted tags after the posedge.
  task automatic step(input vec_t v);
    int   win;
    sb_t  e;
    logic signed [48:0] exp_dist;
    logic exp_hit;
    @(negedge clk);
    req_valid = v.rv;
    rsp_ready = v.rr;
    if (v.inf) begin
      exp_hit  = 1'b0;
      exp_dist = INFINITY_49;
    end else begin
      exp_hit  = cyc[0];
      exp_dist = 49'(cyc) * 49'sd7919 - 49'sd100000;
    end
    dp_hit  = exp_hit;
    dp_dist = exp_dist;
    #1;
    win = -1;
    for (int i = 0; i < NREQ; i++) if (v.rdy[i]) win = i;
    chk("req_ready", 256'(req_ready), 256'(v.rdy));
    chk("rsp_valid", 256'(rsp_valid), 256'(v.vld));
    chk("dp_stall", 256'(dp_stall), 256'(v.vld & ~v.rr));
    chk("busy", 256'(busy), 256'(v.busy));
    if (win >= 0) begin
      chk("dp_ray_orig", 256'(dp_ray_orig), 256'(req_ray_orig[win]));
      chk("dp_inv_ray_dir", 256'(dp_inv_ray_dir), 256'(req_inv_dir[win]));
      chk("dp_div_by_zero", 256'(dp_div_by_zero), 256'(req_div_by_zero[win]));
      chk("dp_box", 256'(dp_box), 256'(req_box[win]));
      e.id  = 2'(win);
      e.tag = req_tag[win];
      sb.push_back(e);
    end else begin
      chk("dp_bubble", 256'({dp_ray_orig, dp_inv_ray_dir, dp_div_by_zero}) | 256'(dp_box), 256'(0));
    end
    if (v.vld) begin
      chk("rsp_id", 256'(rsp_id), 256'(v.id));
      chk("rsp_hit", 256'(rsp_hit), 256'(exp_hit));
      chk("rsp_dist", 256'(rsp_dist), 256'(exp_dist));
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 256'(1), 256'(0));
      end else begin
        chk("rsp_tag", 256'(rsp_tag), 256'(sb[0].tag));
        chk("rsp_order_id", 256'(rsp_id), 256'(sb[0].id));
        if (v.rr) void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (win >= 0) req_tag[win] = req_tag[win] + 16'd1;
    cyc++;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < NREQ; i++) begin
      req_ray_orig[i]    = {3{32'h1000_0000 * 32'(i + 1) + 32'h0000_0011}};
      req_inv_dir[i]     = {3{36'h0_0001_0000 + 36'(i * 3)}};
      req_div_by_zero[i] = 3'(i + 1);
      req_box[i]         = {req_ray_orig[i], ~req_ray_orig[i]};
      req_tag[i]         = 16'h1000 * 16'(i) + 16'h00A5;
    end

    //   rv     rr   rdy    vld id  busy inf
    add(4'b0100, 1, 4'b0100, 0, 0, 0, 0);   // T4: ptr=0, only req2
    add(4'b1010, 1, 4'b1000, 0, 0, 1, 0);   //     req1+req3 -> 3
    add(4'b0010, 1, 4'b0010, 0, 0, 1, 0);   //     then 1
    add(4'b0000, 1, 4'b0000, 0, 0, 1, 0);
    add(4'b0000, 1, 4'b0000, 1, 2, 1, 0);
    add(4'b0000, 1, 4'b0000, 1, 3, 1, 0);
    add(4'b0000, 1, 4'b0000, 1, 1, 1, 0);
    add(4'b0001, 1, 4'b0001, 0, 0, 0, 0);   // T1: req0 tag 00A5
    add(4'b0000, 1, 4'b0000, 0, 0, 1, 0);
    add(4'b0000, 1, 4'b0000, 0, 0, 1, 0);
    add(4'b0000, 1, 4'b0000, 0, 0, 1, 0);
    add(4'b0000, 1, 4'b0000, 1, 0, 1, 1);   // T1 response at +4, T6 miss at infinity
    add(4'b1000, 1, 4'b1000, 0, 0, 0, 0);   // moves ptr to 0
    add(4'b1111, 1, 4'b0001, 0, 0, 1, 0);   // T2: all valid
    add(4'b1111, 1, 4'b0010, 0, 0, 1, 0);
    add(4'b1111, 1, 4'b0100, 0, 0, 1, 0);
    add(4'b1111, 1, 4'b1000, 1, 3, 1, 0);
    add(4'b1111, 1, 4'b0001, 1, 0, 1, 0);
    add(4'b1111, 1, 4'b0010, 1, 1, 1, 0);
    add(4'b1111, 1, 4'b0100, 1, 2, 1, 0);
    add(4'b1111, 1, 4'b1000, 1, 3, 1, 0);
    add(4'b1111, 0, 4'b0000, 1, 0, 1, 0);   // T3: three stalled cycles
    add(4'b1111, 0, 4'b0000, 1, 0, 1, 0);
    add(4'b1111, 0, 4'b0000, 1, 0, 1, 0);
    add(4'b1111, 1, 4'b0001, 1, 0, 1, 0);
    add(4'b1111, 1, 4'b0010, 1, 1, 1, 0);
    add(4'b1111, 1, 4'b0100, 1, 2, 1, 0);
    add(4'b1111, 1, 4'b1000, 1, 3, 1, 0);
    add(4'b0000, 1, 4'b0000, 1, 0, 1, 0);
    add(4'b0000, 1, 4'b0000, 1, 1, 1, 0);
    add(4'b0000, 1, 4'b0000, 1, 2, 1, 0);
    add(4'b0000, 1, 4'b0000, 1, 3, 1, 0);
    add(4'b0000, 1, 4'b0000, 0, 0, 0, 0);

    // Reset state, with requests pending to show req_ready is suppressed.
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 256'(req_ready), 256'(0));
    chk("reset_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("reset_dp_stall", 256'(dp_stall), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_stall_cycles", 256'(stall_cycles), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;

    foreach (tbl[k]) step(tbl[k]);
    chk("stall_cycles_T3", 256'(stall_cycles), 256'(3));
    chk("scoreboard_drained", 256'(sb.size()), 256'(0));

    // T5: three tests in flight, ptr left at 1, then reset.
    add(4'b0100, 1, 4'b0100, 0, 0, 0, 0); step(tbl[$]);
    add(4'b1000, 1, 4'b1000, 0, 0, 1, 0); step(tbl[$]);
    add(4'b0001, 1, 4'b0001, 0, 0, 1, 0); step(tbl[$]);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("T5_busy_in_reset", 256'(busy), 256'(0));
    chk("T5_rsp_valid_in_reset", 256'(rsp_valid), 256'(0));
    chk("T5_req_ready_in_reset", 256'(req_ready), 256'(0));
    chk("T5_stall_cycles_cleared", 256'(stall_cycles), 256'(0));
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    add(4'b0011, 1, 4'b0001, 0, 0, 0, 0); step(tbl[$]);  // first grant is 0, not 1
    add(4'b0000, 1, 4'b0000, 0, 0, 1, 0); step(tbl[$]);
    add(4'b0000, 1, 4'b0000, 0, 0, 1, 0); step(tbl[$]);
    add(4'b0000, 1, 4'b0000, 0, 0, 1, 0); step(tbl[$]);
    add(4'b0000, 1, 4'b0000, 1, 0, 1, 0); step(tbl[$]);
    add(4'b0000, 1, 4'b0000, 0, 0, 0, 0); step(tbl[$]);
    chk("T5_scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
